pc_redirect_unit: RTL and testbench

Program-counter and fetch-control stage that sits directly downstream of the branch unit. It consumes the registered branch decision and jump requests from EX, and selects and holds the next PC. It also generates the IF/ID and ID/EX flush strobes and manages stall and halt for the fetch side of the RV32I pipeline.

---
 rtl/pc_ctrl_pkg.sv | 22 ++
 rtl/pc_redirect_unit_if.sv | 44 ++++
 rtl/pc_redirect_unit_sat_counter16.sv | 33 +++
 rtl/pc_redirect_unit.sv | 125 ++++++++++++
 tb/tb_pc_redirect_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC redirect / fetch-control stage.
// Contents: FSM state enum, PC increment, default reset PC, alignment helper.
package pc_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_FLUSH = 2'd1,
    PC_HALT  = 2'd2
  } pc_state_e;

  // A fetch target is legal only when it is word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage : pc_ctrl_pkg

// File: rtl/pc_redirect_unit_if.sv
// Fetch-control bundle between EX/hazard logic (master) and pc_redirect_unit (slave).
// master: drives stall, branch/jump requests, halt_req, resume; observes pc and status.
// slave : the redirect unit itself.
// Optional PC_REDIRECT_STATS_EN adds redirect_cnt / stall_cnt.
interface pc_redirect_unit_if;
  import pc_ctrl_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            halt_req;
  logic            resume;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_valid;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic            halted;
  logic            misalign;
`ifdef PC_REDIRECT_STATS_EN
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;
`endif

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, halt_req, resume,
    input  pc, pc_plus4, fetch_valid, flush_if_id, flush_id_ex, halted, misalign
`ifdef PC_REDIRECT_STATS_EN
    , input redirect_cnt, stall_cnt
`endif
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, halt_req, resume,
    output pc, pc_plus4, fetch_valid, flush_if_id, flush_id_ex, halted, misalign
`ifdef PC_REDIRECT_STATS_EN
    , output redirect_cnt, stall_cnt
`endif
  );

endinterface : pc_redirect_unit_if

// File: rtl/pc_redirect_unit_sat_counter16.sv
// 16-bit enable counter that saturates at all-ones.
// Ports: clk, rst_n (async active-low), en_i (count enable), cnt_o (count).
module sat_counter16
  import pc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Hold at the ceiling instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter16

// File: rtl/pc_redirect_unit.sv
// PC select / fetch-control stage downstream of the branch unit.
// Ports: clk, rst_n (async active-low), bus (pc_redirect_unit_if.slave):
//   in : stall, branch_taken, branch_target, jump, jump_target, halt_req, resume
//   out: pc, pc_plus4, fetch_valid, flush_if_id, flush_id_ex, halted, misalign
// Macro PC_REDIRECT_STATS_EN adds saturating redirect_cnt / stall_cnt outputs.
module pc_redirect_unit
  import pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_redirect_unit_if.slave bus
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            fetch_valid_q, fetch_valid_d;

  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] target_c;
  logic            redirect_req_c;
  logic            flush_c;
  logic            redirect_acc_c;
  logic            stall_hold_c;

  assign pc_plus4_c     = pc_q + PC_INC;
  assign redirect_req_c = bus.jump | bus.branch_taken;
  // jump wins over a simultaneous taken branch
  assign target_c       = bus.jump ? bus.jump_target : bus.branch_target;

  // Next-state, next-PC and strobe generation.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    misalign_d     = misalign_q;
    flush_c        = 1'b0;
    redirect_acc_c = 1'b0;
    stall_hold_c   = 1'b0;

    unique case (state_q)
      PC_RUN: begin
        if (redirect_req_c) begin
          flush_c        = 1'b1;
          redirect_acc_c = 1'b1;
          if (is_misaligned(target_c)) begin
            // bad target: park in HALT without loading it
            misalign_d = 1'b1;
            state_d    = PC_HALT;
          end else begin
            pc_d    = target_c;
            state_d = PC_FLUSH;
          end
        end else if (bus.halt_req) begin
          state_d = PC_HALT;
        end else if (bus.stall) begin
          stall_hold_c = 1'b1;
        end else begin
          pc_d = pc_plus4_c;
        end
      end
      PC_FLUSH: begin
        // EX holds a bubble here, so its requests are not acted on
        if (!bus.stall) begin
          pc_d = pc_plus4_c;
        end
        state_d = PC_RUN;
      end
      PC_HALT: begin
        if (bus.resume) begin
          state_d = PC_RUN;
        end
      end
      default: begin
        state_d = PC_RUN;
      end
    endcase

    fetch_valid_d = (state_d != PC_HALT);
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PC_RUN;
      pc_q          <= RESET_PC;
      misalign_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      misalign_q    <= misalign_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4_c;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush_if_id = flush_c;
  assign bus.flush_id_ex = flush_c;
  assign bus.halted      = (state_q == PC_HALT);
  assign bus.misalign    = misalign_q;

`ifdef PC_REDIRECT_STATS_EN
  sat_counter16 u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (redirect_acc_c),
    .cnt_o (bus.redirect_cnt)
  );

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stall_hold_c),
    .cnt_o (bus.stall_cnt)
  );
`else
  logic unused_stats_c;
  assign unused_stats_c = redirect_acc_c ^ stall_hold_c;
`endif

endmodule : pc_redirect_unit

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with RESET_PC = 32'h100.
module tb_pc_redirect_unit;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  pc_redirect_unit_if bus_if ();

  pc_redirect_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.stall         = 1'b0;
    bus_if.branch_taken  = 1'b0;
    bus_if.branch_target = 32'h0;
    bus_if.jump          = 1'b0;
    bus_if.jump_target   = 32'h0;
    bus_if.halt_req      = 1'b0;
    bus_if.resume        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus_if.pc !== 32'h100 || bus_if.fetch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first pc=%h fv=%b required pc=00000100 fv=0", bus_if.pc, bus_if.fetch_valid);
    end
    tests_run++;
    if (bus_if.halted !== 1'b0 || bus_if.misalign !== 1'b0 ||
        bus_if.flush_if_id !== 1'b0 || bus_if.flush_id_ex !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags halted=%b misalign=%b flush=%b%b required 0 0 00",
               bus_if.halted, bus_if.misalign, bus_if.flush_if_id, bus_if.flush_id_ex);
    end
    tests_run++;
    if (bus_if.pc_plus4 !== 32'h104) begin
      tests_failed++;
      $display("FAIL reset_pc_plus4 got=%h required=00000104", bus_if.pc_plus4);
    end
    tick();
    tests_run++;
    if (bus_if.pc !== 32'h104 || bus_if.fetch_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_second pc=%h fv=%b required pc=00000104 fv=1", bus_if.pc, bus_if.fetch_valid);
    end
    tick();
    tests_run++;
    if (bus_if.pc !== 32'h108) begin
      tests_failed++;
      $display("FAIL reset_third pc=%h required=00000108", bus_if.pc);
    end
  endtask

  task automatic test_branch_taken();
    tick();
    tick();
    tests_run++;
    if (bus_if.pc !== 32'h110) begin
      tests_failed++;
      $display("FAIL branch_pre pc=%h required=00000110", bus_if.pc);
    end
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_target = 32'h200;
    #1;
    tests_run++;
    if (bus_if.flush_if_id !== 1'b1 || bus_if.flush_id_ex !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_flush flush=%b%b required 11", bus_if.flush_if_id, bus_if.flush_id_ex);
    end
    tick();
    // still asserting branch_taken: this is the pulse during FLUSH
    bus_if.branch_target = 32'h300;
    #1;
    tests_run++;
    if (bus_if.pc !== 32'h200 || bus_if.flush_if_id !== 1'b0 || bus_if.flush_id_ex !== 1'b0) begin
      tests_failed++;
      $display("FAIL branch_target pc=%h flush=%b%b required pc=00000200 flush=00",
               bus_if.pc, bus_if.flush_if_id, bus_if.flush_id_ex);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus_if.pc !== 32'h204) begin
      tests_failed++;
      $display("FAIL branch_after_flush pc=%h required=00000204", bus_if.pc);
    end
  endtask

  task automatic test_jump_priority();
    bus_if.stall         = 1'b1;
    bus_if.jump          = 1'b1;
    bus_if.jump_target   = 32'h40;
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_target = 32'h80;
    #1;
    tests_run++;
    if (bus_if.flush_if_id !== 1'b1 || bus_if.flush_id_ex !== 1'b1) begin
      tests_failed++;
      $display("FAIL jump_flush flush=%b%b required 11", bus_if.flush_if_id, bus_if.flush_id_ex);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus_if.pc !== 32'h40 || bus_if.flush_if_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL jump_wins pc=%h flush=%b required pc=00000040 flush=0", bus_if.pc, bus_if.flush_if_id);
    end
    tick();
    tests_run++;
    if (bus_if.pc !== 32'h44) begin
      tests_failed++;
      $display("FAIL jump_after_flush pc=%h required=00000044", bus_if.pc);
    end
  endtask

  task automatic test_halt_resume();
    bus_if.jump        = 1'b1;
    bus_if.jump_target = 32'h20;
    tick();
    clear_inputs();
    bus_if.stall = 1'b1;   // stalled FLUSH keeps pc at the target
    tick();
    clear_inputs();
    bus_if.halt_req = 1'b1;
    #1;
    tests_run++;
    if (bus_if.pc !== 32'h20 || bus_if.halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_pre pc=%h halted=%b required pc=00000020 halted=0", bus_if.pc, bus_if.halted);
    end
    tick();
    clear_inputs();
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_target = 32'h300;
    bus_if.stall         = 1'b1;
    #1;
    tests_run++;
    if (bus_if.halted !== 1'b1 || bus_if.fetch_valid !== 1'b0 || bus_if.pc !== 32'h20 ||
        bus_if.flush_if_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_enter halted=%b fv=%b pc=%h flush=%b required 1 0 00000020 0",
               bus_if.halted, bus_if.fetch_valid, bus_if.pc, bus_if.flush_if_id);
    end
    tick();
    clear_inputs();
    bus_if.jump        = 1'b1;
    bus_if.jump_target = 32'h500;
    #1;
    tests_run++;
    if (bus_if.halted !== 1'b1 || bus_if.pc !== 32'h20 || bus_if.flush_id_ex !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_ignore_branch halted=%b pc=%h flush=%b required 1 00000020 0",
               bus_if.halted, bus_if.pc, bus_if.flush_id_ex);
    end
    tick();
    clear_inputs();
    bus_if.resume = 1'b1;
    #1;
    tests_run++;
    if (bus_if.halted !== 1'b1 || bus_if.pc !== 32'h20) begin
      tests_failed++;
      $display("FAIL halt_ignore_jump halted=%b pc=%h required 1 00000020", bus_if.halted, bus_if.pc);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus_if.halted !== 1'b0 || bus_if.pc !== 32'h20 || bus_if.fetch_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL resume_first halted=%b pc=%h fv=%b required 0 00000020 1",
               bus_if.halted, bus_if.pc, bus_if.fetch_valid);
    end
    tick();
    tests_run++;
    if (bus_if.pc !== 32'h24) begin
      tests_failed++;
      $display("FAIL resume_second pc=%h required=00000024", bus_if.pc);
    end
  endtask

  task automatic test_misalign();
    bus_if.branch_taken  = 1'b1;
    bus_if.branch_target = 32'h202;
    #1;
    tests_run++;
    if (bus_if.flush_if_id !== 1'b1 || bus_if.flush_id_ex !== 1'b1) begin
      tests_failed++;
      $display("FAIL misalign_flush flush=%b%b required 11", bus_if.flush_if_id, bus_if.flush_id_ex);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus_if.misalign !== 1'b1 || bus_if.halted !== 1'b1 || bus_if.pc !== 32'h24 ||
        bus_if.fetch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_halt misalign=%b halted=%b pc=%h fv=%b required 1 1 00000024 0",
               bus_if.misalign, bus_if.halted, bus_if.pc, bus_if.fetch_valid);
    end
    bus_if.resume = 1'b1;
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus_if.misalign !== 1'b1 || bus_if.halted !== 1'b0 || bus_if.pc !== 32'h24) begin
      tests_failed++;
      $display("FAIL misalign_sticky misalign=%b halted=%b pc=%h required 1 0 00000024",
               bus_if.misalign, bus_if.halted, bus_if.pc);
    end
  endtask

  task automatic test_wrap_async_reset();
    bus_if.jump        = 1'b1;
    bus_if.jump_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus_if.pc !== 32'hFFFF_FFFC || bus_if.pc_plus4 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_pre pc=%h pc_plus4=%h required fffffffc 00000000", bus_if.pc, bus_if.pc_plus4);
    end
    tick();
    tests_run++;
    if (bus_if.pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_zero pc=%h required=00000000", bus_if.pc);
    end
    bus_if.jump        = 1'b1;
    bus_if.jump_target = 32'h400;
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (bus_if.pc !== 32'h400) begin
      tests_failed++;
      $display("FAIL async_pre pc=%h required=00000400", bus_if.pc);
    end
    // pull reset mid-cycle, well away from any clock edge
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.pc !== 32'h100 || bus_if.misalign !== 1'b0 || bus_if.fetch_valid !== 1'b0 ||
        bus_if.halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset pc=%h misalign=%b fv=%b halted=%b required 00000100 0 0 0",
               bus_if.pc, bus_if.misalign, bus_if.fetch_valid, bus_if.halted);
    end
    #1;
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus_if.pc !== 32'h104 || bus_if.fetch_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset pc=%h fv=%b required 00000104 1", bus_if.pc, bus_if.fetch_valid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_branch_taken();
    test_jump_priority();
    test_halt_resume();
    test_misalign();
    test_wrap_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pc_redirect_unit
